divu_seq: RTL
=============

Name: divu_seq

Overview:
- Iterative unsigned divider for the EX stage of the 5-stage MIPS pipeline; sits directly upstream of the HI/LO register pair and feeds it.
- Accepts operands rs/rt from EX, computes one quotient bit per clock (restoring division), then presents remainder (HI) and quotient (LO) with a one-cycle done pulse for HI/LO capture.
- Exposes busy so hazard/stall logic can freeze IF/ID/EX while the divide is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a divide; sampled on rising edge.
- abort  input  1  pipeline flush; cancels an in-flight divide.
- dividend  input  WIDTH  numerator (rs value).
- divisor  input  WIDTH  denominator (rt value).
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse: results valid, HI/LO must capture.
- quotient  output  WIDTH  to LO.
- remainder  output  WIDTH  to HI.
- div_by_zero  output  1  sticky with results: last completed divide had divisor==0.

Behaviour:
- One clock clk; reset rst synchronous, active-high.
- Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter=0. Reset mid-RUN discards the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1 at edge k, divisor!=0: latch divisor; working quotient reg <= dividend; partial remainder <= 0; counter <= 0; state <= RUN; busy=1 from edge k.
- IDLE/DONE + start=1, divisor==0: state <= DONE at edge k; quotient <= {WIDTH{1}}; remainder <= dividend; div_by_zero <= 1; done=1 for the following cycle only.
- RUN, each edge: {r,q} <= {r,q}<<1; if the shifted r >= divisor (WIDTH+1-bit compare, no overflow loss), r <= r-divisor and q[0] <= 1; counter++.
- After WIDTH iterations (edge k+WIDTH): state <= DONE; busy <= 0; done <= 1 for exactly one cycle; quotient/remainder updated; div_by_zero <= 0.
- DONE: done deasserts after one cycle; results and div_by_zero hold until the next accepted start or rst. State remains DONE; DONE behaves as IDLE for start acceptance.
- start while RUN: ignored; operands not relatched; the in-flight result is unaffected.
- abort while RUN: state <= IDLE at that edge; busy <= 0; no done; quotient/remainder keep their previous completed values.
- abort and start on the same edge: abort wins; start is dropped.
- abort outside RUN: no effect.
- quotient/remainder outputs change only on completion, never mid-iteration. Internal working registers are separate from the output registers.
- Latency: start at edge k -> done visible in the cycle after edge k+WIDTH (32 cycles at default). Divide-by-zero: 1 cycle.

Optional Feature:
- Macro DIVU_SEQ_SIGNED_EN.
- Defined: adds input port is_signed (1 bit, sampled with start) to support MIPS DIV.
  - Operands are converted to magnitudes before iterating. Quotient is negated if the signs differ (truncation toward zero). Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0.
  - Latency is unchanged; sign fixup is folded into the completion edge.
- Undefined: no is_signed port; all divides are unsigned.

Test Plan:
- dividend=100, divisor=7, start 1 cycle -> busy high 32 cycles; done pulse at cycle 33; quotient=14, remainder=2, div_by_zero=0.
- dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0. Then dividend=5, divisor=0xFFFFFFFF -> quotient=0, remainder=5.
- divisor=0, dividend=0x1234 -> done on the next cycle; quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1, busy never high.
- start 100/7; at iteration 10 pulse start with 9/3 -> ignored; result is 14/2 at cycle 33, with exactly one done pulse.
- start 100/7; abort at iteration 5 -> busy=0 next cycle, no done, outputs hold the prior result. Repeat with rst at iteration 5 -> all outputs 0.
- With DIVU_SEQ_SIGNED_EN: is_signed=1, -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Then 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.

Source files
------------

// File: rtl/divu_seq_if.sv
// divu_seq_if: bundles the EX-stage request and HI/LO result signals of the
// iterative divider.
//   master modport: EX / hazard side (drives start, abort, operands; reads
//                   busy, done, quotient, remainder, div_by_zero)
//   slave modport : the divider itself
// Optional macro DIVU_SEQ_SIGNED_EN adds the is_signed request bit (MIPS DIV).
interface divu_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
`ifdef DIVU_SEQ_SIGNED_EN
   logic             is_signed;

   modport master (
      output start, abort, dividend, divisor, is_signed,
      input  busy, done, quotient, remainder, div_by_zero
   );
   modport slave (
      input  start, abort, dividend, divisor, is_signed,
      output busy, done, quotient, remainder, div_by_zero
   );
`else
   modport master (
      output start, abort, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );
   modport slave (
      input  start, abort, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
`endif
endinterface

// File: rtl/divu_seq.sv
// divu_seq: iterative restoring divider for the EX stage, feeding HI/LO.
// One quotient bit per clock; WIDTH iterations after an accepted start the
// result registers update and done pulses for one cycle.
// Ports:
//   clk  - pipeline clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - divu_seq_if.slave: start/abort/dividend/divisor in;
//          busy/done/quotient(LO)/remainder(HI)/div_by_zero out
// Parameters: WIDTH (operand width), CNT_W (iteration counter, 2^CNT_W > WIDTH)
// Optional macro DIVU_SEQ_SIGNED_EN: signed divide (MIPS DIV) selected by
// bus.is_signed; operands iterate as magnitudes and the sign fixup is applied
// on the completion edge, so latency is identical to the unsigned case.
module divu_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic      clk,
   input  logic      rst,
   divu_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] r_reg, r_next;       // working partial remainder
   logic [WIDTH-1:0] q_reg, q_next;       // working dividend/quotient shifter
   logic [WIDTH-1:0] dvsr_reg, dvsr_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             neg_q_reg, neg_q_next;
   logic             neg_r_reg, neg_r_next;
   logic [WIDTH-1:0] quot_reg, quot_next;
   logic [WIDTH-1:0] rem_reg, rem_next;
   logic             dbz_reg, dbz_next;
   logic             done_reg, done_next;

   // Operand conditioning at start time.
   logic [WIDTH-1:0] start_a;
   logic [WIDTH-1:0] start_b;
   logic             start_neg_q;
   logic             start_neg_r;

`ifdef DIVU_SEQ_SIGNED_EN
   logic a_neg;
   logic b_neg;
   assign a_neg       = bus.is_signed & bus.dividend[WIDTH-1];
   assign b_neg       = bus.is_signed & bus.divisor[WIDTH-1];
   // -(most negative) wraps to itself, which is the correct unsigned magnitude.
   assign start_a     = a_neg ? -bus.dividend : bus.dividend;
   assign start_b     = b_neg ? -bus.divisor  : bus.divisor;
   assign start_neg_q = a_neg ^ b_neg;
   assign start_neg_r = a_neg;
`else
   assign start_a     = bus.dividend;
   assign start_b     = bus.divisor;
   assign start_neg_q = 1'b0;
   assign start_neg_r = 1'b0;
`endif

   // One restoring step. The working remainder is always < divisor, so the
   // shifted value is < 2*divisor and a WIDTH+1-bit difference cannot wrap:
   // its top bit is exactly the "shifted < divisor" borrow.
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             fits;
   logic [WIDTH-1:0] iter_r;
   logic [WIDTH-1:0] iter_q;

   assign shifted = {r_reg, q_reg[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvsr_reg};
   assign fits    = ~diff[WIDTH];
   assign iter_r  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign iter_q  = {q_reg[WIDTH-2:0], fits};

   always_comb begin
      state_next = state_reg;
      r_next     = r_reg;
      q_next     = q_reg;
      dvsr_next  = dvsr_reg;
      cnt_next   = cnt_reg;
      neg_q_next = neg_q_reg;
      neg_r_next = neg_r_reg;
      quot_next  = quot_reg;
      rem_next   = rem_reg;
      dbz_next   = dbz_reg;
      done_next  = 1'b0;

      case (state_reg)
         IDLE, DONE: begin
            if (bus.start) begin
               if (bus.divisor == '0) begin
                  // Divide-by-zero resolves immediately without iterating.
                  state_next = DONE;
                  quot_next  = '1;
                  rem_next   = bus.dividend;
                  dbz_next   = 1'b1;
                  done_next  = 1'b1;
               end else begin
                  state_next = RUN;
                  dvsr_next  = start_b;
                  q_next     = start_a;
                  r_next     = '0;
                  cnt_next   = '0;
                  neg_q_next = start_neg_q;
                  neg_r_next = start_neg_r;
               end
            end
         end
         RUN: begin
            if (bus.abort) begin
               // Flush: drop the operation, leave the last results visible.
               state_next = IDLE;
            end else begin
               r_next   = iter_r;
               q_next   = iter_q;
               cnt_next = cnt_reg + 1'b1;
               if (cnt_reg == LAST_CNT) begin
                  state_next = DONE;
                  done_next  = 1'b1;
                  dbz_next   = 1'b0;
                  quot_next  = neg_q_reg ? -iter_q : iter_q;
                  rem_next   = neg_r_reg ? -iter_r : iter_r;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         r_reg     <= '0;
         q_reg     <= '0;
         dvsr_reg  <= '0;
         cnt_reg   <= '0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
         quot_reg  <= '0;
         rem_reg   <= '0;
         dbz_reg   <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         r_reg     <= r_next;
         q_reg     <= q_next;
         dvsr_reg  <= dvsr_next;
         cnt_reg   <= cnt_next;
         neg_q_reg <= neg_q_next;
         neg_r_reg <= neg_r_next;
         quot_reg  <= quot_next;
         rem_reg   <= rem_next;
         dbz_reg   <= dbz_next;
         done_reg  <= done_next;
      end
   end

   assign bus.busy        = (state_reg == RUN);
   assign bus.done        = done_reg;
   assign bus.quotient    = quot_reg;
   assign bus.remainder   = rem_reg;
   assign bus.div_by_zero = dbz_reg;

endmodule
